fpu_issue_sequencer: RTL and testbench
======================================

Name: fpu_issue_sequencer

Overview:
Sequences one floating-point operation at a time through the FPU and the FP register file. It does four things:
- accepts a decoded FP request;
- resolves the rounding mode against fcsr.frm;
- drives register-file read addresses and the FPU operation select, then waits for f_ready with a timeout;
- writes the result back and accumulates exception flags into fcsr.fflags.

It sits between decode/issue and the FPU/register-file pair, and owns the fcsr frm/fflags state.

Parameters:
TIMEOUT_CYCLES, 64, max cycles spent in WAIT before abort (>=2)
CNT_W, 7, width of the timeout counter (must hold TIMEOUT_CYCLES-1)

Ports:
CLK  input  1  clock, rising edge
RST  input  1  synchronous active-high reset
req_valid  input  1  FP request valid
req_ready  output  1  sequencer can accept a request
req_funct7  input  8  FPU operation select
req_rm  input  3  instruction rounding-mode field (3'b111 = dynamic)
req_rs1  input  5  source register 1
req_rs2  input  5  source register 2
req_rd  input  5  destination register
f_rs1  output  5  register-file read address 1
f_rs2  output  5  register-file read address 2
funct_7  output  8  operation select to FPU
frm  output  3  resolved rounding mode to FPU
fpu_start  output  1  one-cycle launch pulse to FPU
FPU_out  input  32  FPU result
flags  input  5  FPU flags {NV,DZ,OF,UF,NX}
f_ready  input  1  FPU result valid
f_wen  output  1  register-file write enable
f_rd  output  5  write address
f_w_data  output  32  write data
csr_frm_we  input  1  CSR write of frm
csr_frm_wdata  input  3  frm write data
csr_fflags_we  input  1  CSR write of fflags
csr_fflags_wdata  input  5  fflags write data
fcsr_frm  output  3  current fcsr.frm
fcsr_fflags  output  5  current fcsr.fflags
done  output  1  one-cycle pulse: operation committed
illegal  output  1  one-cycle pulse: illegal rounding mode
timeout_err  output  1  one-cycle pulse: FPU timeout abort

Behaviour:
- One clock CLK; RST is synchronous and active-high.
- Reset: state=IDLE. Every output is 0 except req_ready=1. This includes fcsr_frm=0, fcsr_fflags=0, the internal latches and the counter.
- Reset mid-operation: return to IDLE immediately, with no writeback and no pulses. A late f_ready after reset is ignored.
- States: IDLE, ISSUE, WAIT, WB, ABORT.
- IDLE:
  - req_ready=1; accept on req_valid.
  - On accept, latch funct7, rs1, rs2 and rd, and resolve the rounding mode: rm_eff = (req_rm==3'b111) ? fcsr_frm : req_rm.
  - If rm_eff is 101, 110 or 111, go to ABORT with the illegal flavour. Otherwise latch rm_eff and go to ISSUE.
- ISSUE (1 cycle):
  - fpu_start=1.
  - f_rs1/f_rs2/funct_7/frm are driven from the latches. They hold these values through WAIT; the register file reads combinationally.
  - Clear the counter, then go to WAIT.
- WAIT:
  - On f_ready: capture FPU_out and flags, then go to WB.
  - Otherwise increment the counter. When counter==TIMEOUT_CYCLES-1 without f_ready, go to ABORT with the timeout flavour.
  - f_ready in any other state is ignored.
- WB (1 cycle):
  - f_wen=1, f_rd=latched rd, f_w_data=captured result, done=1.
  - Next fflags = (csr_fflags_we ? csr_fflags_wdata : fcsr_fflags) | captured flags.
  - Go to IDLE.
- ABORT (1 cycle): pulse illegal or timeout_err as appropriate, with no write and no fflags change. Go to IDLE.
- Outside WB, csr_fflags_we loads fflags directly.
- csr_frm_we loads frm in any state, visible the next cycle. An in-flight operation keeps the rm_eff it latched at accept.
- f_wen, done, illegal and timeout_err are each high for exactly one cycle per operation. They are mutually exclusive.
- Latency:
  - Accept at cycle T, ISSUE at T+1, WAIT from T+2.
  - f_ready at cycle W gives WB at W+1.
  - Minimum accept-to-done is 3 cycles.
  - The next accept is no earlier than the cycle after WB/ABORT.

Test Plan:
- Reset then idle: RST high for 2 cycles -> req_ready=1, fcsr_frm=0, fcsr_fflags=0, f_wen=0.
- Static rm: req_rm=001, rd=5, FPU returns f_ready 3 cycles after fpu_start with FPU_out=0x40490FDB and flags=00001 -> frm=001 during WAIT, f_wen=1 with f_rd=5 and f_w_data=0x40490FDB, fcsr_fflags=00001, done one cycle.
- Dynamic rm and mid-flight change:
  - fcsr_frm=010, req_rm=111 -> frm=010.
  - csr_frm_we=1, wdata=100 during WAIT -> frm stays 010 until WB; fcsr_frm=100 afterwards.
  - Second op with rm=111 uses 100.
- Illegal rm: req_rm=101, or req_rm=111 with fcsr_frm=110 -> fpu_start never asserts, illegal pulses at T+1, no f_wen, fflags unchanged.
- Timeout with TIMEOUT_CYCLES=4: f_ready never asserts -> timeout_err pulses after 4 WAIT cycles, then req_ready=1. A later stray f_ready is ignored (no f_wen).
- Flag collision and reset mid-op:
  - csr_fflags_we=1 with wdata=10000 in the WB cycle while captured flags=00100 -> fcsr_fflags=10100.
  - RST asserted in WAIT -> IDLE next cycle, no done, fcsr_fflags=0.

Source files
------------

// File: rtl/fpu_issue_sequencer.sv
// ---------------------------------------------------------------------------
// fpu_issue_sequencer
//
// Sequences one floating-point operation at a time through the FPU and the
// FP register file, and owns the fcsr rounding-mode (frm) and accrued
// exception flag (fflags) state.
//
// Flow: IDLE accepts a request and resolves the rounding mode, ISSUE launches
// the FPU, WAIT holds operands until f_ready (or times out), WB writes the
// result back and accrues flags, ABORT reports an illegal rounding mode or a
// timeout without touching architectural state.
//
// Ports
//   CLK, RST                    clock, synchronous active-high reset
//   req_valid/req_ready         request handshake
//   req_funct7/rm/rs1/rs2/rd    decoded FP request fields
//   f_rs1/f_rs2                 register-file read addresses (ISSUE/WAIT)
//   funct_7/frm/fpu_start       FPU operation select, rounding mode, launch
//   FPU_out/flags/f_ready       FPU result, exception flags, result valid
//   f_wen/f_rd/f_w_data         register-file write port (WB)
//   csr_frm_*/csr_fflags_*      CSR writes of frm / fflags
//   fcsr_frm/fcsr_fflags        current fcsr contents
//   done/illegal/timeout_err    one-cycle completion / abort pulses
// ---------------------------------------------------------------------------
module fpu_issue_sequencer #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [7:0]  req_funct7,
    input  logic [2:0]  req_rm,
    input  logic [4:0]  req_rs1,
    input  logic [4:0]  req_rs2,
    input  logic [4:0]  req_rd,
    output logic [4:0]  f_rs1,
    output logic [4:0]  f_rs2,
    output logic [7:0]  funct_7,
    output logic [2:0]  frm,
    output logic        fpu_start,
    input  logic [31:0] FPU_out,
    input  logic [4:0]  flags,
    input  logic        f_ready,
    output logic        f_wen,
    output logic [4:0]  f_rd,
    output logic [31:0] f_w_data,
    input  logic        csr_frm_we,
    input  logic [2:0]  csr_frm_wdata,
    input  logic        csr_fflags_we,
    input  logic [4:0]  csr_fflags_wdata,
    output logic [2:0]  fcsr_frm,
    output logic [4:0]  fcsr_fflags,
    output logic        done,
    output logic        illegal,
    output logic        timeout_err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_WB    = 3'd3,
        S_ABORT = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t            state_r;
    state_t            state_s;
    logic [7:0]        funct7_r;
    logic [4:0]        rs1_r;
    logic [4:0]        rs2_r;
    logic [4:0]        rd_r;
    logic [2:0]        rm_r;
    logic [31:0]       res_r;
    logic [4:0]        flg_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              abort_timeout_r;   // 1: ABORT reports timeout, 0: illegal rm
    logic [2:0]        frm_r;
    logic [4:0]        fflags_r;
    logic [2:0]        rm_eff_s;
    logic              rm_bad_s;

    // Rounding-mode resolution: dynamic (111) takes the current fcsr.frm, and
    // 101/110/111 after resolution are reserved encodings.
    always_comb begin
        rm_eff_s = req_rm;
        rm_bad_s = 1'b0;
        if (req_rm == 3'b111) begin
            rm_eff_s = frm_r;
        end else begin
            rm_eff_s = req_rm;
        end
        if (rm_eff_s >= 3'b101) begin
            rm_bad_s = 1'b1;
        end else begin
            rm_bad_s = 1'b0;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (req_valid) begin
                    state_s = rm_bad_s ? S_ABORT : S_ISSUE;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_ISSUE: state_s = S_WAIT;
            S_WAIT: begin
                // f_ready wins over the timeout on the last allowed cycle
                if (f_ready) begin
                    state_s = S_WB;
                end else if (cnt_r == CNT_LAST) begin
                    state_s = S_ABORT;
                end else begin
                    state_s = S_WAIT;
                end
            end
            S_WB:    state_s = S_IDLE;
            S_ABORT: state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    // State register plus request latches, wait counter and result capture
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r         <= S_IDLE;
            funct7_r        <= 8'd0;
            rs1_r           <= 5'd0;
            rs2_r           <= 5'd0;
            rd_r            <= 5'd0;
            rm_r            <= 3'd0;
            res_r           <= 32'd0;
            flg_r           <= 5'd0;
            cnt_r           <= '0;
            abort_timeout_r <= 1'b0;
        end else begin
            state_r <= state_s;
            case (state_r)
                S_IDLE: begin
                    if (req_valid) begin
                        funct7_r        <= req_funct7;
                        rs1_r           <= req_rs1;
                        rs2_r           <= req_rs2;
                        rd_r            <= req_rd;
                        abort_timeout_r <= 1'b0;
                        if (!rm_bad_s) begin
                            rm_r <= rm_eff_s;
                        end
                    end
                end
                S_ISSUE: cnt_r <= '0;
                S_WAIT: begin
                    if (f_ready) begin
                        res_r <= FPU_out;
                        flg_r <= flags;
                    end else if (cnt_r == CNT_LAST) begin
                        abort_timeout_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // fcsr state: CSR writes land any time; WB merges new flags on top of a
    // same-cycle CSR write so neither source is lost.
    always_ff @(posedge CLK) begin
        if (RST) begin
            frm_r    <= 3'd0;
            fflags_r <= 5'd0;
        end else begin
            if (csr_frm_we) begin
                frm_r <= csr_frm_wdata;
            end
            if (state_r == S_WB) begin
                fflags_r <= (csr_fflags_we ? csr_fflags_wdata : fflags_r) | flg_r;
            end else if (csr_fflags_we) begin
                fflags_r <= csr_fflags_wdata;
            end
        end
    end

    // Moore output decode; every output is sourced from flops
    always_comb begin
        req_ready   = 1'b0;
        f_rs1       = 5'd0;
        f_rs2       = 5'd0;
        funct_7     = 8'd0;
        frm         = 3'd0;
        fpu_start   = 1'b0;
        f_wen       = 1'b0;
        f_rd        = 5'd0;
        f_w_data    = 32'd0;
        done        = 1'b0;
        illegal     = 1'b0;
        timeout_err = 1'b0;
        case (state_r)
            S_IDLE: req_ready = 1'b1;
            S_ISSUE, S_WAIT: begin
                // operands held steady for the combinational register-file read
                f_rs1     = rs1_r;
                f_rs2     = rs2_r;
                funct_7   = funct7_r;
                frm       = rm_r;
                fpu_start = (state_r == S_ISSUE);
            end
            S_WB: begin
                f_wen    = 1'b1;
                f_rd     = rd_r;
                f_w_data = res_r;
                done     = 1'b1;
            end
            S_ABORT: begin
                illegal     = ~abort_timeout_r;
                timeout_err = abort_timeout_r;
            end
            default: req_ready = 1'b0;
        endcase
    end

    assign fcsr_frm    = frm_r;
    assign fcsr_fflags = fflags_r;

endmodule

// File: tb/tb_fpu_issue_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fpu_issue_sequencer
//
// Self-checking bench for fpu_issue_sequencer (TIMEOUT_CYCLES=4). A
// transaction-level reference tracks fcsr.frm / fcsr.fflags and predicts, per
// operation, the resolved rounding mode, the outcome (writeback, illegal or
// timeout) and the cycle at which each pulse appears. Inputs change and
// outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_fpu_issue_sequencer;

    localparam int TO = 4;

    logic        CLK;
    logic        RST;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_funct7;
    logic [2:0]  req_rm;
    logic [4:0]  req_rs1;
    logic [4:0]  req_rs2;
    logic [4:0]  req_rd;
    logic [4:0]  f_rs1;
    logic [4:0]  f_rs2;
    logic [7:0]  funct_7;
    logic [2:0]  frm;
    logic        fpu_start;
    logic [31:0] FPU_out;
    logic [4:0]  flags;
    logic        f_ready;
    logic        f_wen;
    logic [4:0]  f_rd;
    logic [31:0] f_w_data;
    logic        csr_frm_we;
    logic [2:0]  csr_frm_wdata;
    logic        csr_fflags_we;
    logic [4:0]  csr_fflags_wdata;
    logic [2:0]  fcsr_frm;
    logic [4:0]  fcsr_fflags;
    logic        done;
    logic        illegal;
    logic        timeout_err;

    int errors = 0;
    int checks = 0;

    // reference fcsr contents
    logic [2:0] m_frm;
    logic [4:0] m_fflags;

    fpu_issue_sequencer #(.TIMEOUT_CYCLES(TO), .CNT_W(3)) dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_funct7(req_funct7), .req_rm(req_rm),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd),
        .f_rs1(f_rs1), .f_rs2(f_rs2), .funct_7(funct_7), .frm(frm),
        .fpu_start(fpu_start), .FPU_out(FPU_out), .flags(flags),
        .f_ready(f_ready), .f_wen(f_wen), .f_rd(f_rd), .f_w_data(f_w_data),
        .csr_frm_we(csr_frm_we), .csr_frm_wdata(csr_frm_wdata),
        .csr_fflags_we(csr_fflags_we), .csr_fflags_wdata(csr_fflags_wdata),
        .fcsr_frm(fcsr_frm), .fcsr_fflags(fcsr_fflags),
        .done(done), .illegal(illegal), .timeout_err(timeout_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic frm_write(input logic [2:0] v);
        csr_frm_we    = 1'b1;
        csr_frm_wdata = v;
        @(negedge CLK);
        csr_frm_we = 1'b0;
        m_frm      = v;
        chk("frm_write", {29'd0, fcsr_frm}, {29'd0, m_frm});
    endtask

    task automatic fflags_write(input logic [4:0] v);
        csr_fflags_we    = 1'b1;
        csr_fflags_wdata = v;
        @(negedge CLK);
        csr_fflags_we = 1'b0;
        m_fflags      = v;
        chk("fflags_write", {27'd0, fcsr_fflags}, {27'd0, m_fflags});
    endtask

    // One complete operation starting from IDLE. dly = WAIT cycle (1-based)
    // carrying f_ready; dly > TO means the FPU never answers.
    task automatic run_op(input logic [7:0] f7, input logic [2:0] rm,
                          input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                          input int dly, input logic [31:0] res, input logic [4:0] fl,
                          input bit frm_wr, input logic [2:0] frm_wv,
                          input bit ff_wr, input logic [4:0] ff_wv);
        logic [2:0] rm_eff;
        bit         wb;
        rm_eff = (rm == 3'b111) ? m_frm : rm;
        wb     = 1'b0;
        chk("idle_ready", {31'd0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_funct7 = f7;
        req_rm     = rm;
        req_rs1    = a;
        req_rs2    = b;
        req_rd     = d;
        @(negedge CLK);
        // scramble request fields: the sequencer must work from its latches
        req_valid  = 1'b0;
        req_funct7 = 8'($urandom);
        req_rm     = 3'($urandom);
        req_rs1    = 5'($urandom);
        req_rs2    = 5'($urandom);
        req_rd     = 5'($urandom);
        if (rm_eff >= 3'b101) begin
            chk("ill_pulse", {31'd0, illegal}, 32'd1);
            chk("ill_start", {31'd0, fpu_start}, 32'd0);
            chk("ill_wen", {31'd0, f_wen}, 32'd0);
            chk("ill_tmo", {31'd0, timeout_err}, 32'd0);
            @(negedge CLK);
            chk("ill_idle", {31'd0, req_ready}, 32'd1);
            chk("ill_once", {31'd0, illegal}, 32'd0);
            chk("ill_fflags", {27'd0, fcsr_fflags}, {27'd0, m_fflags});
            return;
        end
        chk("iss_start", {31'd0, fpu_start}, 32'd1);
        chk("iss_rs1", {27'd0, f_rs1}, {27'd0, a});
        chk("iss_rs2", {27'd0, f_rs2}, {27'd0, b});
        chk("iss_f7", {24'd0, funct_7}, {24'd0, f7});
        chk("iss_frm", {29'd0, frm}, {29'd0, rm_eff});
        chk("iss_ready", {31'd0, req_ready}, 32'd0);
        @(negedge CLK);
        for (int k = 1; k <= TO; k++) begin
            chk("wait_frm", {29'd0, frm}, {29'd0, rm_eff});
            chk("wait_rs1", {27'd0, f_rs1}, {27'd0, a});
            chk("wait_start", {31'd0, fpu_start}, 32'd0);
            chk("wait_wen", {31'd0, f_wen}, 32'd0);
            chk("wait_fcsr_frm", {29'd0, fcsr_frm}, {29'd0, m_frm});
            if (frm_wr && k == 1) begin
                csr_frm_we    = 1'b1;
                csr_frm_wdata = frm_wv;
            end
            if (k == dly) begin
                f_ready = 1'b1;
                FPU_out = res;
                flags   = fl;
            end
            @(negedge CLK);
            f_ready    = 1'b0;
            FPU_out    = $urandom;
            flags      = 5'($urandom);
            csr_frm_we = 1'b0;
            if (frm_wr && k == 1) m_frm = frm_wv;
            if (k == dly) begin
                wb = 1'b1;
                break;
            end
        end
        if (wb) begin
            chk("wb_wen", {31'd0, f_wen}, 32'd1);
            chk("wb_rd", {27'd0, f_rd}, {27'd0, d});
            chk("wb_data", f_w_data, res);
            chk("wb_done", {31'd0, done}, 32'd1);
            chk("wb_excl", {30'd0, illegal, timeout_err}, 32'd0);
            chk("wb_fcsr_frm", {29'd0, fcsr_frm}, {29'd0, m_frm});
            if (ff_wr) begin
                csr_fflags_we    = 1'b1;
                csr_fflags_wdata = ff_wv;
                m_fflags         = ff_wv | fl;
            end else begin
                m_fflags = m_fflags | fl;
            end
            @(negedge CLK);
            csr_fflags_we = 1'b0;
            chk("wb_fflags", {27'd0, fcsr_fflags}, {27'd0, m_fflags});
            chk("wb_idle", {31'd0, req_ready}, 32'd1);
            chk("wb_once", {30'd0, f_wen, done}, 32'd0);
        end else begin
            chk("tmo_pulse", {31'd0, timeout_err}, 32'd1);
            chk("tmo_excl", {29'd0, f_wen, done, illegal}, 32'd0);
            @(negedge CLK);
            chk("tmo_idle", {31'd0, req_ready}, 32'd1);
            chk("tmo_once", {31'd0, timeout_err}, 32'd0);
            chk("tmo_fflags", {27'd0, fcsr_fflags}, {27'd0, m_fflags});
            // a stray late result must be ignored
            f_ready = 1'b1;
            @(negedge CLK);
            f_ready = 1'b0;
            chk("stray_wen", {30'd0, f_wen, done}, 32'd0);
            chk("stray_idle", {31'd0, req_ready}, 32'd1);
        end
    endtask

    initial begin
        RST = 1'b1;
        req_valid = 1'b0; req_funct7 = 8'd0; req_rm = 3'd0;
        req_rs1 = 5'd0; req_rs2 = 5'd0; req_rd = 5'd0;
        FPU_out = 32'd0; flags = 5'd0; f_ready = 1'b0;
        csr_frm_we = 1'b0; csr_frm_wdata = 3'd0;
        csr_fflags_we = 1'b0; csr_fflags_wdata = 5'd0;
        m_frm = 3'd0;
        m_fflags = 5'd0;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_frm", {29'd0, fcsr_frm}, 32'd0);
        chk("rst_fflags", {27'd0, fcsr_fflags}, 32'd0);
        chk("rst_outs", {26'd0, f_wen, fpu_start, done, illegal, timeout_err, |f_w_data}, 32'd0);
        @(negedge CLK);

        // static rounding mode, result 3 cycles after fpu_start
        run_op(8'h10, 3'b001, 5'd1, 5'd2, 5'd5, 3, 32'h40490FDB, 5'b00001, 1'b0, 3'd0, 1'b0, 5'd0);
        // dynamic rm with frm rewritten mid-flight, then reuse of the new frm
        frm_write(3'b010);
        run_op(8'h20, 3'b111, 5'd3, 5'd4, 5'd6, 4, 32'h3F800000, 5'b00010, 1'b1, 3'b100, 1'b0, 5'd0);
        run_op(8'h21, 3'b111, 5'd7, 5'd8, 5'd9, 1, 32'hC0000000, 5'b00000, 1'b0, 3'd0, 1'b0, 5'd0);
        // illegal rounding modes, static and dynamic
        run_op(8'h30, 3'b101, 5'd1, 5'd1, 5'd1, 1, 32'h0, 5'b11111, 1'b0, 3'd0, 1'b0, 5'd0);
        frm_write(3'b110);
        run_op(8'h31, 3'b111, 5'd1, 5'd1, 5'd1, 1, 32'h0, 5'b11111, 1'b0, 3'd0, 1'b0, 5'd0);
        frm_write(3'b000);
        // timeout
        run_op(8'h40, 3'b000, 5'd2, 5'd3, 5'd4, TO + 3, 32'h0, 5'b11111, 1'b0, 3'd0, 1'b0, 5'd0);
        // flag collision in the WB cycle
        fflags_write(5'b00000);
        run_op(8'h50, 3'b011, 5'd10, 5'd11, 5'd12, 2, 32'h12345678, 5'b00100, 1'b0, 3'd0, 1'b1, 5'b10000);

        // reset in WAIT: back to IDLE with no writeback, late f_ready ignored
        frm_write(3'b011);
        req_valid = 1'b1; req_rm = 3'b001; req_rd = 5'd13;
        @(negedge CLK);
        req_valid = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        m_frm = 3'd0;
        m_fflags = 5'd0;
        chk("mid_rst_ready", {31'd0, req_ready}, 32'd1);
        chk("mid_rst_done", {30'd0, done, f_wen}, 32'd0);
        chk("mid_rst_fflags", {27'd0, fcsr_fflags}, 32'd0);
        chk("mid_rst_frm", {29'd0, fcsr_frm}, 32'd0);
        f_ready = 1'b1; FPU_out = 32'hDEADBEEF; flags = 5'b11111;
        @(negedge CLK);
        f_ready = 1'b0;
        chk("mid_rst_late", {30'd0, done, f_wen}, 32'd0);
        chk("mid_rst_fflags2", {27'd0, fcsr_fflags}, 32'd0);

        // randomized operations
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) frm_write(3'($urandom));
            if ($urandom_range(0, 5) == 0) fflags_write(5'($urandom));
            run_op(8'($urandom), 3'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                   int'($urandom_range(1, TO + 2)), $urandom, 5'($urandom),
                   1'($urandom), 3'($urandom), 1'($urandom), 5'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
